// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream input and instruction-memory write bus of the loader
interface program_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;

   // master: stream source and memory sink; slave: the loader itself
   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that fills instruction memory and gates cpu reset
module program_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   program_loader_if.slave   bus,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_cause,
   output logic [ADDR_W:0]   words_written
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   state_t      state;
   state_t      state_next;
   logic [15:0] len;
   logic [23:0] word;
   logic [7:0]  acc;
   logic [1:0]  idx;
   logic        accept;
   logic        arm;
   logic [15:0] len_rx;
   logic [15:0] ww_next;

   assign accept  = bus.in_valid && bus.in_ready;
   assign arm     = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign len_rx  = {len[15:8], bus.in_data};
   assign ww_next = 16'(words_written) + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_LEN_HI;
         S_LEN_HI:  if (accept) state_next = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_rx > MAX_N)       state_next = S_ERROR;
               else if (len_rx == 16'd0) state_next = S_CHECK;
               else                      state_next = S_PAYLOAD;
            end
         end
         S_PAYLOAD: if (accept && idx == 2'd3) state_next = S_WRITE;
         S_WRITE:   state_next = (ww_next == len) ? S_CHECK : S_PAYLOAD;
         S_CHECK: begin
            if (accept) state_next = (bus.in_data == acc) ? S_DONE : S_ERROR;
         end
         S_DONE:    if (start) state_next = S_LEN_HI;
         S_ERROR:   if (start) state_next = S_LEN_HI;
         default:   state_next = S_IDLE;
      endcase
   end

   // a write still pending on the reset edge must not reach memory
   always_comb begin
      bus.in_ready = 1'b0;
      bus.mem_we   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      cpu_reset    = 1'b1;
      case (state)
         S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
         end
         S_WRITE: begin
            bus.mem_we = !reset;
            busy       = 1'b1;
         end
         S_DONE: begin
            done      = 1'b1;
            cpu_reset = 1'b0;
         end
         S_ERROR:  error = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len           <= '0;
         word          <= '0;
         acc           <= '0;
         idx           <= '0;
         err_cause     <= 2'b00;
         words_written <= '0;
         bus.mem_addr  <= '0;
         bus.mem_data  <= '0;
      end else begin
         if (arm) begin
            err_cause     <= 2'b00;
            words_written <= '0;
            acc           <= '0;
            idx           <= '0;
         end
         case (state)
            S_LEN_HI: if (accept) len[15:8] <= bus.in_data;
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= bus.in_data;
                  if (len_rx > MAX_N) err_cause <= 2'b01;
               end
            end
            S_PAYLOAD: begin
               if (accept) begin
                  word <= {word[15:0], bus.in_data};
                  acc  <= acc ^ bus.in_data;
                  idx  <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     bus.mem_addr <= words_written[ADDR_W-1:0];
                     bus.mem_data <= {word, bus.in_data};
                  end
               end
            end
            S_WRITE:  words_written <= words_written + 1'b1;
            S_CHECK: begin
               if (accept && bus.in_data != acc) err_cause <= 2'b10;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cpu_reset, busy, done, error;
   logic [1:0]  err_cause;
   logic [10:0] words_written;

   int errors = 0;
   int checks = 0;
   int write_count = 0;
   int accepted = 0;
   int we_run = 0;
   int max_we_run = 0;
   logic [9:0]  wa [$];
   logic [31:0] wd [$];
   logic [7:0]  frame [$];

   program_loader_if #(.ADDR_W(10)) bus ();

   program_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
      .err_cause(err_cause), .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_data);
         write_count++;
         we_run++;
         if (we_run > max_we_run) max_we_run = we_run;
      end else begin
         we_run = 0;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && reset === 1'b0) accepted++;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL handshake_timeout byte=%h in_ready=%b exp=1", b, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < frame.size(); i++) send_byte(frame[i], $urandom_range(0, max_gap));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_two_words(input string tag, input int base);
      checks++;
      if (write_count - base !== 2) begin
         errors++; $display("FAIL %s_writes got=%0d exp=2", tag, write_count - base);
      end else begin
         checks++;
         if (wa[base] !== 10'd0 || wd[base] !== 32'h12345678) begin
            errors++; $display("FAIL %s_word0 got=%0d:%h exp=0:12345678", tag, wa[base], wd[base]);
         end
         checks++;
         if (wa[base+1] !== 10'd1 || wd[base+1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL %s_word1 got=%0d:%h exp=1:deadbeef", tag, wa[base+1], wd[base+1]);
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.in_ready, bus.mem_we, busy, done, error, cpu_reset} !== 6'b000001) begin
         errors++; $display("FAIL reset_flags got=%b exp=000001",
                            {bus.in_ready, bus.mem_we, busy, done, error, cpu_reset});
      end
      checks++;
      if (bus.mem_addr !== 10'd0 || bus.mem_data !== 32'd0 || err_cause !== 2'b00 || words_written !== 11'd0) begin
         errors++; $display("FAIL reset_regs got=%h %h %b %0d exp=0 0 00 0",
                            bus.mem_addr, bus.mem_data, err_cause, words_written);
      end
   endtask

   task automatic test_good_load();
      int base = write_count;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL good_armed busy=%b in_ready=%b exp=1 1", busy, bus.in_ready);
      end
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
      send_frame(0);
      check_two_words("good", base);
      checks++;
      if ({done, cpu_reset, error, busy} !== 4'b1000 || words_written !== 11'd2) begin
         errors++; $display("FAIL good_status got=%b ww=%0d exp=1000 ww=2",
                            {done, cpu_reset, error, busy}, words_written);
      end
   endtask

   task automatic test_bad_checksum();
      int base = write_count;
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2B};
      send_frame(0);
      check_two_words("badck", base);
      checks++;
      if ({error, done, cpu_reset} !== 3'b101 || err_cause !== 2'b10) begin
         errors++; $display("FAIL badck_status got=%b cause=%b exp=101 cause=10",
                            {error, done, cpu_reset}, err_cause);
      end
   endtask

   task automatic test_len_range();
      int base = write_count;
      pulse_start();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      checks++;
      if (error !== 1'b1 || err_cause !== 2'b01 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL len_range got err=%b cause=%b rdy=%b busy=%b exp=1 01 0 0",
                            error, err_cause, bus.in_ready, busy);
      end
      checks++;
      if (write_count !== base) begin
         errors++; $display("FAIL len_range_writes got=%0d exp=0", write_count - base);
      end
   endtask

   task automatic test_zero_length();
      int base = write_count;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00};
      send_frame(0);
      checks++;
      if (done !== 1'b1 || words_written !== 11'd0 || write_count !== base) begin
         errors++; $display("FAIL zero_good got done=%b ww=%0d writes=%0d exp=1 0 0",
                            done, words_written, write_count - base);
      end
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h05};
      send_frame(0);
      checks++;
      if (error !== 1'b1 || err_cause !== 2'b10 || done !== 1'b0) begin
         errors++; $display("FAIL zero_bad got err=%b cause=%b done=%b exp=1 10 0",
                            error, err_cause, done);
      end
   endtask

   task automatic test_backpressure();
      int base = write_count;
      int acc0;
      max_we_run = 0;
      pulse_start();
      acc0 = accepted;
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
      send_frame(3);
      check_two_words("bp", base);
      checks++;
      if (accepted - acc0 !== 11) begin
         errors++; $display("FAIL bp_accepts got=%0d exp=11", accepted - acc0);
      end
      checks++;
      if (max_we_run !== 1) begin
         errors++; $display("FAIL bp_we_pulse got=%0d exp=1", max_we_run);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL bp_done got=%b exp=1", done);
      end
   endtask

   task automatic test_reset_reload();
      int base;
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
      send_frame(0);
      base = write_count;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.mem_we !== 1'b0) begin
         errors++; $display("FAIL rst_mid_we got=%b exp=0", bus.mem_we);
      end
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      checks++;
      if (write_count !== base) begin
         errors++; $display("FAIL rst_mid_writes got=%0d exp=0", write_count - base);
      end
      test_good_load();
      base = write_count;
      pulse_start();
      checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || words_written !== 11'd0) begin
         errors++; $display("FAIL rearm got cpu_reset=%b done=%b busy=%b ww=%0d exp=1 0 1 0",
                            cpu_reset, done, busy, words_written);
      end
      frame = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
      send_frame(0);
      checks++;
      if (cpu_reset !== 1'b1) begin
         errors++; $display("FAIL reload_cpu_reset got=%b exp=1", cpu_reset);
      end
      frame = '{8'hDD, 8'h00};
      send_frame(0);
      checks++;
      if (write_count - base !== 1) begin
         errors++; $display("FAIL reload_writes got=%0d exp=1", write_count - base);
      end else begin
         checks++;
         if (wa[base] !== 10'd0 || wd[base] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL reload_word got=%0d:%h exp=0:aabbccdd", wa[base], wd[base]);
         end
      end
      checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b0 || words_written !== 11'd1) begin
         errors++; $display("FAIL reload_done got done=%b cpu_reset=%b ww=%0d exp=1 0 1",
                            done, cpu_reset, words_written);
      end
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_len_range();
      test_zero_length();
      test_backpressure();
      test_reset_reload();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
